mf_trigger_discriminator: RTL and testbench

MF_TRIGGER_DISCRIMINATOR -- requirements
Module: mf_trigger_discriminator

---
 rtl/mf_trigger_discriminator.sv | 150 +++++++++++++++
 tb/tb_mf_trigger_discriminator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mf_trigger_discriminator.sv
// Two-lane matched-filter trigger discriminator: threshold, peak-find, holdoff.
// Optional saturation veto is enabled by defining MF_TRIG_SAT_VETO_EN.
module mf_trigger_discriminator #(
  parameter int INBITS       = 16,
  parameter int HOLDOFF_BITS = 8,
  parameter int MAX_PEAK     = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic signed [INBITS-1:0] in0_i,
  input  logic signed [INBITS-1:0] in1_i,
  input  logic [1:0]               sat_i,
  input  logic signed [INBITS-1:0] thresh_i,
  input  logic [HOLDOFF_BITS-1:0]  holdoff_i,
  output logic                     trig_valid_o,
  output logic signed [INBITS-1:0] trig_peak_o,
  output logic                     trig_lane_o,
  output logic [15:0]              trig_time_o,
  output logic [15:0]              trig_count_o,
  output logic                     sat_veto_o
);
  localparam int PKW = $clog2(MAX_PEAK + 1);

  typedef enum logic [1:0] {IDLE, ARMED, PEAK, HOLDOFF} state_t;

  state_t                    state;
  logic [15:0]               ts, sts;
  logic signed [INBITS-1:0]  s0, s1, thr_q;
  logic signed [INBITS-1:0]  pk_val, upd_val, ld_val;
  logic                      pk_lane, upd_lane, ld_lane;
  logic [15:0]               pk_time, upd_time;
  logic [PKW-1:0]            pk_cnt;
  logic [HOLDOFF_BITS-1:0]   hold_cnt;
  logic                      any_above, peak_done;
  logic                      pk_open, pk_cont, pk_close, win_vetoed;

  always_comb begin
    any_above = (s0 > thr_q) || (s1 > thr_q);
    peak_done = !any_above || (pk_cnt == PKW'(MAX_PEAK));
    ld_lane   = (s1 > s0);
    ld_val    = ld_lane ? s1 : s0;
    // lane 0 is the earlier sample, so it gets first claim on a new maximum
    upd_val   = pk_val;
    upd_lane  = pk_lane;
    upd_time  = pk_time;
    if (s0 > upd_val) begin
      upd_val  = s0;
      upd_lane = 1'b0;
      upd_time = sts;
    end
    if (s1 > upd_val) begin
      upd_val  = s1;
      upd_lane = 1'b1;
      upd_time = sts;
    end
    pk_open  = en_i && (state == ARMED) && any_above;
    pk_cont  = en_i && (state == PEAK) && !peak_done;
    pk_close = en_i && (state == PEAK) && peak_done;
  end

`ifdef MF_TRIG_SAT_VETO_EN
  logic [1:0] ssat;
  logic       mark, veto_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ssat   <= '0;
      mark   <= 1'b0;
      veto_q <= 1'b0;
    end else begin
      ssat   <= sat_i;
      veto_q <= pk_close && mark;
      if (pk_open)      mark <= |ssat;
      else if (pk_cont) mark <= mark | (|ssat);
    end
  end

  assign win_vetoed = mark;
  assign sat_veto_o = veto_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat_i;
  assign win_vetoed = 1'b0;
  assign sat_veto_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ts           <= '0;
      sts          <= '0;
      s0           <= '0;
      s1           <= '0;
      thr_q        <= '0;
      pk_val       <= '0;
      pk_lane      <= 1'b0;
      pk_time      <= '0;
      pk_cnt       <= '0;
      hold_cnt     <= '0;
      trig_valid_o <= 1'b0;
      trig_peak_o  <= '0;
      trig_lane_o  <= 1'b0;
      trig_time_o  <= '0;
      trig_count_o <= '0;
    end else begin
      ts           <= ts + 16'd1;
      sts          <= ts;
      s0           <= in0_i;
      s1           <= in1_i;
      trig_valid_o <= 1'b0;
      if (state == IDLE || state == ARMED) thr_q <= thresh_i;
      if (!en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: if (pk_open) begin
            state   <= PEAK;
            pk_val  <= ld_val;
            pk_lane <= ld_lane;
            pk_time <= sts;
            pk_cnt  <= '0;
          end
          PEAK: if (pk_close) begin
            if (!win_vetoed) begin
              trig_valid_o <= 1'b1;
              trig_peak_o  <= pk_val;
              trig_lane_o  <= pk_lane;
              trig_time_o  <= pk_time;
              if (trig_count_o != 16'hFFFF) trig_count_o <= trig_count_o + 16'd1;
            end
            hold_cnt <= holdoff_i;
            state    <= (holdoff_i == '0) ? ARMED : HOLDOFF;
          end else begin
            pk_val  <= upd_val;
            pk_lane <= upd_lane;
            pk_time <= upd_time;
            pk_cnt  <= pk_cnt + PKW'(1);
          end
          HOLDOFF: begin
            if (hold_cnt <= HOLDOFF_BITS'(1)) state <= ARMED;
            else hold_cnt <= hold_cnt - HOLDOFF_BITS'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mf_trigger_discriminator.sv
// Scoreboard bench for mf_trigger_discriminator: directed vectors, queued expectations.
module tb_mf_trigger_discriminator;
  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               en_i = 1'b0;
  logic signed [15:0] in0_i = '0, in1_i = '0, thresh_i = 16'sd100;
  logic [1:0]         sat_i = '0;
  logic [7:0]         holdoff_i = 8'd4;
  logic               trig_valid_o, trig_lane_o, sat_veto_o;
  logic signed [15:0] trig_peak_o;
  logic [15:0]        trig_time_o, trig_count_o;

  mf_trigger_discriminator dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .in0_i(in0_i), .in1_i(in1_i),
    .sat_i(sat_i), .thresh_i(thresh_i), .holdoff_i(holdoff_i),
    .trig_valid_o(trig_valid_o), .trig_peak_o(trig_peak_o), .trig_lane_o(trig_lane_o),
    .trig_time_o(trig_time_o), .trig_count_o(trig_count_o), .sat_veto_o(sat_veto_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] peak;
    logic        lane;
    logic [15:0] tm;
    logic [15:0] cnt;
    logic        veto;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          nchecks = 0, nerr = 0;
  int          cyc = 0;
  logic [15:0] exp_count = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int a, input int b, input logic [1:0] s);
    in0_i = 16'(a);
    in1_i = 16'(b);
    sat_i = s;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 2'b00);
  endtask

  // Expectation for a window whose last peak sample is input now; out_cyc is the pulse cycle.
  task automatic push(input int peak, input logic lane, input int tm, input logic veto,
                      input int out_cyc);
    exp_t e;
    if (!veto && exp_count != 16'hFFFF) exp_count++;
    e.peak = 16'(peak);
    e.lane = lane;
    e.tm   = 16'(tm);
    e.cnt  = exp_count;
    e.veto = veto;
    e.cyc  = out_cyc;
    q.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, trig_valid_o}, 0);
    chk({tag, "_veto"},  {31'd0, sat_veto_o}, 0);
    chk({tag, "_peak"},  {16'd0, trig_peak_o}, 0);
    chk({tag, "_lane"},  {31'd0, trig_lane_o}, 0);
    chk({tag, "_time"},  {16'd0, trig_time_o}, 0);
    chk({tag, "_count"}, {16'd0, trig_count_o}, 0);
  endtask

  always @(negedge clk) begin
    if (trig_valid_o || sat_veto_o) begin
      if (q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_pulse: valid=%b veto=%b peak=%0d at cycle %0d",
                 trig_valid_o, sat_veto_o, trig_peak_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("trig_valid", {31'd0, trig_valid_o}, {31'd0, !e.veto});
        chk("sat_veto", {31'd0, sat_veto_o}, {31'd0, e.veto});
        chk("trig_count", {16'd0, trig_count_o}, {16'd0, e.cnt});
        if (!e.veto) begin
          chk("trig_peak", {16'd0, trig_peak_o}, {16'd0, e.peak});
          chk("trig_lane", {31'd0, trig_lane_o}, {31'd0, e.lane});
          chk("trig_time", {16'd0, trig_time_o}, {16'd0, e.tm});
        end
      end
    end
  end

  initial begin
    int c;
    // reset: cycle 0 is the first cycle after the last reset edge, timestamp 0
    repeat (2) begin @(posedge clk); #1; end
    rst_i = 1'b0;
    cyc = 0;
    chk_idle_outputs("reset");

    en_i = 1'b1;
    idle(3);

    // rising pulse, peak moves to lane 1
    c = cyc;
    push(140, 1'b1, c + 2, 1'b0, c + 5);
    drive(50, 50, 2'b00);
    drive(120, 90, 2'b00);
    drive(130, 140, 2'b00);
    drive(80, 60, 2'b00);
    idle(8);

    // equal lanes pick lane 0; above-threshold samples during holdoff ignored
    c = cyc;
    push(150, 1'b0, c, 1'b0, c + 3);
    drive(150, 150, 2'b00);
    drive(0, 0, 2'b00);
    repeat (4) drive(200, 200, 2'b00);
    idle(6);

    // equal to threshold is not above
    drive(100, 100, 2'b00);
    idle(4);
    chk("count_after_equal", {16'd0, trig_count_o}, 2);

    // MAX_PEAK close with zero holdoff, then re-arm while still above
    holdoff_i = 8'd0;
    c = cyc;
    push(500, 1'b0, c, 1'b0, c + 67);
    push(500, 1'b0, c + 66, 1'b0, c + 102);
    repeat (100) drive(500, 500, 2'b00);
    holdoff_i = 8'd4;
    idle(10);

    // enable dropped mid-peak: window discarded
    drive(300, 300, 2'b00);
    drive(300, 300, 2'b00);
    en_i = 1'b0;
    idle(5);
    chk("valid_after_en_drop", {31'd0, trig_valid_o}, 0);
    chk("count_after_en_drop", {16'd0, trig_count_o}, 4);
    en_i = 1'b1;
    idle(3);

    // reset mid-peak: no pulse, everything cleared
    drive(300, 300, 2'b00);
    drive(300, 300, 2'b00);
    in0_i = '0;
    in1_i = '0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    cyc = 0;
    exp_count = '0;
    chk_idle_outputs("midpeak_reset");
    idle(3);

    // saturation flagged on the peak sample
    c = cyc;
`ifdef MF_TRIG_SAT_VETO_EN
    push(2047, 1'b0, c, 1'b1, c + 3);
`else
    push(2047, 1'b0, c, 1'b0, c + 3);
`endif
    drive(2047, 0, 2'b01);
    idle(8);

    // timestamp wrap: peak sample at 0xFFFF, then one just after the wrap
    while (cyc < 65535) drive(0, 0, 2'b00);
    c = cyc;
    push(500, 1'b0, 16'hFFFF, 1'b0, c + 3);
    drive(500, 0, 2'b00);
    idle(6);
    c = cyc;
    push(450, 1'b1, c & 16'hFFFF, 1'b0, c + 3);
    drive(400, 450, 2'b00);
    idle(8);

    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
